// File: rtl/key_event_sched.sv
// key_event_sched
//   Captures one-cycle key press pulses from a 4x4 scanner into a pending
//   register. A round-robin arbiter moves one pending key per cycle into a
//   small event FIFO, which a consumer drains.
//
// Handshake: an event transfers on a rising edge when ev_valid && ev_ready.
//   ev_valid depends only on stored state, ev_ready may be tied high, and a
//   ready with nothing valid is ignored.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset (beats clr and all else)
//   key_pulse  in   [15:0] press pulses, bit i = key i
//   clr        in   synchronous flush of pend, FIFO and overflow
//   ev_valid   out  FIFO head holds an event
//   ev_code    out  [3:0] key index at the FIFO head (0 when empty)
//   ev_ready   in   consumer accepts the head event
//   ev_count   out  [AW:0] number of stored events, 0..DEPTH
//   pend       out  [15:0] pending-request register (debug view)
//   overflow   out  sticky: a press merged into an already pending request
module key_event_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   key_pulse,
  input  logic          clr,
  output logic          ev_valid,
  output logic [3:0]    ev_code,
  input  logic          ev_ready,
  output logic [AW:0]   ev_count,
  output logic [15:0]   pend,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [15:0]   pend_q, pend_d;
  logic [3:0]    last_grant_q, last_grant_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          grant_found;
  logic [3:0]    grant_idx;
  logic [3:0]    cand;
  logic [15:0]   grant_onehot;

  // Round-robin search: first pending bit at or after last_grant+1, wrapping
  // 15 -> 0. The 16th candidate wraps back to last_grant itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= 16; k++) begin
      cand = last_grant_q + 4'(k);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A full FIFO can still accept a grant when the head leaves in the same
  // cycle, so push eligibility looks at pop.
  assign pop          = (count_q != '0) && ev_ready;
  assign push         = grant_found && ((count_q != DEPTH_C) || pop);
  assign grant_onehot = push ? (16'(1) << grant_idx) : '0;

  always_comb begin
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    if (clr) begin
      // Flush everything except the arbiter position; the grant and pulses
      // of this cycle are dropped.
      pend_d     = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // A pulse on the bit granted this cycle re-arms it (new press).
      pend_d = (pend_q & ~grant_onehot) | key_pulse;
      if ((key_pulse & pend_q & ~grant_onehot) != '0) begin
        overflow_d = 1'b1;
      end
      if (push) begin
        last_grant_d = grant_idx;
        wr_ptr_d     = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      last_grant_q <= 4'd15;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) begin
      mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign ev_valid = (count_q != '0);
  assign ev_code  = ev_valid ? mem_q[rd_ptr_q] : 4'd0;
  assign ev_count = count_q;
  assign pend     = pend_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_sched.sv
module tb_key_event_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   key_pulse = '0;
  logic          clr = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ev_valid;
  logic [3:0]    ev_code;
  logic [AW:0]   ev_count;
  logic [15:0]   pend;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [3:0]  exp_q[$];
  logic [15:0] m_pend = '0;
  int          m_last = 15;
  bit          m_ovf  = 1'b0;

  key_event_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .clr       (clr),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .pend      (pend),
    .overflow  (overflow)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one rising edge with the given inputs.
  task automatic model_step(input logic [15:0] kp, input bit c, input bit r, input bit rs);
    int   g;
    bit   do_pop;
    logic [15:0] gmask;
    if (rs) begin
      m_pend = '0; exp_q.delete(); m_ovf = 1'b0; m_last = 15;
    end else if (c) begin
      m_pend = '0; exp_q.delete(); m_ovf = 1'b0;
    end else begin
      do_pop = (exp_q.size() > 0) && r;
      g = -1;
      if (m_pend != 0 && (exp_q.size() < DEPTH || do_pop)) begin
        for (int k = 1; k <= 16; k++) begin
          if (g < 0 && m_pend[(m_last + k) % 16]) g = (m_last + k) % 16;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      gmask = '0;
      if (g >= 0) begin
        exp_q.push_back(4'(g));
        m_last = g;
        gmask[g] = 1'b1;
      end
      if ((kp & m_pend & ~gmask) != 0) m_ovf = 1'b1;
      m_pend = (m_pend & ~gmask) | kp;
    end
  endtask

  // Driver: apply inputs for one cycle, advance the model at the edge.
  task automatic cyc(input logic [15:0] kp, input bit c, input bit r, input bit rs);
    key_pulse = kp; clr = c; ev_ready = r; rst = rs;
    @(posedge clk);
    model_step(kp, c, r, rs);
    #1;
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
  endtask

  // Scoreboard compare, every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
      check("m_code",  32'(ev_code),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("m_count", 32'(ev_count), 32'(exp_q.size()));
      check("m_pend",  32'(pend),     32'(m_pend));
      check("m_ovf",   32'(overflow), 32'(m_ovf));
    end
  end

  initial begin
    logic [3:0] got[$];
    logic [15:0] kp;

    // Reset
    do_reset();
    cyc('0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_count", 32'(ev_count), 0);
    check("rst_pend",  32'(pend), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_code",  32'(ev_code), 0);

    // Single key, two-edge latency
    cyc(16'h0020, 1'b0, 1'b1, 1'b0);
    check("sk_valid_e1", 32'(ev_valid), 0);
    check("sk_pend_e1",  32'(pend), 32'h20);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("sk_valid_e2", 32'(ev_valid), 1);
    check("sk_code_e2",  32'(ev_code), 5);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("sk_count_e3", 32'(ev_count), 0);
    check("sk_ovf_e3",   32'(overflow), 0);

    // Simultaneous keys 0 and 15
    do_reset();
    cyc(16'h8001, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("sim_code0", 32'(ev_code), 0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("sim_count", 32'(ev_count), 2);
    check("sim_pend",  32'(pend), 0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("sim_code1", 32'(ev_code), 15);

    // Round-robin wrap: last_grant=3, then keys 0 and 3
    do_reset();
    cyc(16'h0008, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc(16'h0009, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("rr_first", 32'(ev_code), 0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("rr_second", 32'(ev_code), 3);
    cyc('0, 1'b0, 1'b1, 1'b0);

    // Full FIFO, then drain order
    do_reset();
    for (int k = 1; k <= 6; k++) cyc(16'(1) << k, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(ev_count), 4);
    check("full_pend",  32'(pend), 32'h60);
    check("full_ovf",   32'(overflow), 0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (ev_valid) got.push_back(ev_code);
      cyc('0, 1'b0, 1'b1, 1'b0);
    end
    check("drain_len", 32'(got.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check("drain_order", 32'(got[i]), 32'(i + 1));
    end

    // Overflow with FIFO full, then clr
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(16'(1) << k, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc(16'h0080, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("ovf_pre", 32'(overflow), 0);
    cyc(16'h0080, 1'b0, 1'b0, 1'b0);
    check("ovf_set",   32'(overflow), 1);
    check("ovf_pend7", 32'(pend[7]), 1);
    cyc('0, 1'b1, 1'b0, 1'b0);
    check("clr_ovf",   32'(overflow), 0);
    check("clr_pend",  32'(pend), 0);
    check("clr_count", 32'(ev_count), 0);

    // Reset mid-operation
    do_reset();
    cyc(16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(16'h0004, 1'b0, 1'b0, 1'b0);
    cyc(16'h0008, 1'b0, 1'b0, 1'b0);
    cyc(16'h00F0, 1'b0, 1'b0, 1'b0);
    check("mid_count", 32'(ev_count), 3);
    check("mid_pend",  32'(pend), 32'hF0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_valid", 32'(ev_valid), 0);
    check("mid_rst_count", 32'(ev_count), 0);
    check("mid_rst_pend",  32'(pend), 0);
    cyc(16'h0004, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("mid_key2_valid", 32'(ev_valid), 1);
    check("mid_key2_code",  32'(ev_code), 2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    kp = '0;
        2, 3:    kp = 16'(1) << $urandom_range(0, 15);
        4:       kp = 16'($urandom) & 16'($urandom);
        default: kp = 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
      cyc(kp,
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 2) != 0) : 1'b0,
          ($urandom_range(0, 399) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
